ln_stat_ctrl: RTL and testbench



---
 rtl/ln_stat_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ln_stat_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_stat_ctrl.sv
// LayerNorm statistics sequencer: streams one N-element vector into the mean
// and Ex2 units, then collects E[x] / E[x^2] and hands them on with a done pulse.
module ln_stat_ctrl #(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 8,
  parameter int STAT_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [1:0]        i_alpha,
  input  logic [7:0]        i_inv_n,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_unit_valid,
  output logic [DATA_W-1:0] o_unit_x,
  output logic [1:0]        o_unit_alpha,
  output logic [7:0]        o_unit_inv_n,
  input  logic              i_ex_done,
  input  logic              i_ex2_done,
  input  logic [STAT_W-1:0] i_ex,
  input  logic [STAT_W-1:0] i_ex2,
  output logic              o_busy,
  output logic              o_done,
  output logic [STAT_W-1:0] o_mean,
  output logic [STAT_W-1:0] o_ex2,
  output logic              o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, addr_q, cnt_q;
  logic                drain_q;
  logic [TW-1:0]       wait_q;
  logic                ex_flag_q, ex2_flag_q;
  logic [STAT_W-1:0]   ex_res_q, ex2_res_q, mean_q, ex2_q;
  logic [1:0]          alpha_q;
  logic [7:0]          inv_n_q;
  logic [1:0]          vpipe_q;
  logic [DATA_W-1:0]   x_q;

  logic accept, last_rd, any_done, both_now, timeout_hit;

  assign accept      = i_start && (i_len != '0);
  assign last_rd     = (cnt_q == len_q - ADDR_W'(1));
  assign any_done    = i_ex_done || i_ex2_done;
  // A done arriving this cycle counts, so o_done follows the later done by one cycle.
  assign both_now    = (ex_flag_q || i_ex_done) && (ex2_flag_q || i_ex2_done);
  assign timeout_hit = (wait_q == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_STREAM;
      S_STREAM: begin
        if (any_done)     state_d = S_IDLE;
        else if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN:  if (drain_q) state_d = S_WAIT;
      S_WAIT: begin
        if (both_now)         state_d = S_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    o_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        o_err  = i_start && (i_len == '0);
      end
      S_STREAM: begin
        o_rd_en = 1'b1;
        o_err   = any_done;
      end
      S_WAIT:   o_err  = !both_now && timeout_hit;
      S_DONE:   o_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      len_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      wait_q     <= '0;
      ex_flag_q  <= 1'b0;
      ex2_flag_q <= 1'b0;
      ex_res_q   <= '0;
      ex2_res_q  <= '0;
      mean_q     <= '0;
      ex2_q      <= '0;
      alpha_q    <= '0;
      inv_n_q    <= '0;
      vpipe_q    <= '0;
      x_q        <= '0;
    end else begin
      // An aborted job must not leak in-flight elements to the units.
      vpipe_q <= (state_q == S_STREAM && any_done) ? 2'b00 : {vpipe_q[0], o_rd_en};
      if (vpipe_q[0]) x_q <= i_rd_data;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            len_q      <= i_len;
            addr_q     <= i_base_addr;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            wait_q     <= '0;
            ex_flag_q  <= 1'b0;
            ex2_flag_q <= 1'b0;
            alpha_q    <= i_alpha;
            inv_n_q    <= i_inv_n;
          end
        end
        S_STREAM: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_q + ADDR_W'(1);
        end
        S_DRAIN:  drain_q <= 1'b1;
        S_WAIT: begin
          wait_q <= wait_q + TW'(1);
          if (both_now) begin
            mean_q <= i_ex_done  ? i_ex  : ex_res_q;
            ex2_q  <= i_ex2_done ? i_ex2 : ex2_res_q;
          end
        end
        default: ;
      endcase

      if (state_q == S_DRAIN || state_q == S_WAIT) begin
        if (i_ex_done) begin
          ex_flag_q <= 1'b1;
          ex_res_q  <= i_ex;
        end
        if (i_ex2_done) begin
          ex2_flag_q <= 1'b1;
          ex2_res_q  <= i_ex2;
        end
      end
    end
  end

  assign o_rd_addr    = addr_q;
  assign o_unit_valid = vpipe_q[1];
  assign o_unit_x     = x_q;
  assign o_unit_alpha = alpha_q;
  assign o_unit_inv_n = inv_n_q;
  assign o_mean       = mean_q;
  assign o_ex2        = ex2_q;

endmodule

// File: tb/tb_ln_stat_ctrl.sv
// Bench for ln_stat_ctrl: directed job table, multi-cycle corner sequences and
// random jobs, all judged against a cycle-relative model of one job.
`timescale 1ns/1ps
module tb_ln_stat_ctrl;
  localparam int DATA_W  = 9;
  localparam int ADDR_W  = 8;
  localparam int STAT_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int NONE    = 1000;
  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;

  typedef struct {
    string name;
    int len; int base; int alpha; int inv_n;
    int dex; int dex2; int ex; int ex2;
    int early; int poke; int b2b;
    int exp_kind; int exp_rel;
  } job_t;

  logic clk = 1'b0;
  logic rstn, start;
  logic [ADDR_W-1:0] len, base, rd_addr;
  logic [1:0] alpha, unit_alpha;
  logic [7:0] inv_n, unit_inv_n;
  logic rd_en, unit_valid, ex_done, ex2_done, busy, done, err;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] unit_x;
  logic [STAT_W-1:0] ex, ex2, mean_o, ex2_o;
  logic [DATA_W-1:0] mem [256];

  int checks = 0, errors = 0;
  int held_mean = 0, held_ex2 = 0, cur_alpha = 0, cur_inv = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  ln_stat_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAT_W(STAT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_len(len), .i_base_addr(base),
    .i_alpha(alpha), .i_inv_n(inv_n), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .o_unit_valid(unit_valid), .o_unit_x(unit_x),
    .o_unit_alpha(unit_alpha), .o_unit_inv_n(unit_inv_n), .i_ex_done(ex_done),
    .i_ex2_done(ex2_done), .i_ex(ex), .i_ex2(ex2), .o_busy(busy), .o_done(done),
    .o_mean(mean_o), .o_ex2(ex2_o), .o_err(err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},   int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_valid"},   int'(unit_valid), 0);
    chk({tag, "_unit_x"},  int'(unit_x), 0);
    chk({tag, "_alpha"},   int'(unit_alpha), 0);
    chk({tag, "_inv_n"},   int'(unit_inv_n), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_done"},    int'(done), 0);
    chk({tag, "_mean"},    int'(mean_o), 0);
    chk({tag, "_ex2"},     int'(ex2_o), 0);
    chk({tag, "_err"},     int'(err), 0);
  endtask

  function automatic job_t mk(input string nm, input int l, input int b, input int a, input int inv,
                              input int dx, input int dx2, input int e, input int e2, input int early,
                              input int poke, input int b2b, input int kind, input int rel);
    job_t j;
    j.name = nm; j.len = l; j.base = b; j.alpha = a; j.inv_n = inv;
    j.dex = dx; j.dex2 = dx2; j.ex = e; j.ex2 = e2; j.early = early; j.poke = poke;
    j.b2b = b2b; j.exp_kind = kind; j.exp_rel = rel;
    return j;
  endfunction

  // Cycle numbers are relative to the accepting edge: cycle 1 is the first read.
  // Last element reaches the units in cycle N+2; waiting spans cycles N+3 .. N+2+TIMEOUT.
  function automatic void model(input job_t j, output int kind, output int rel);
    int wait_first, wait_last, a1, a2, latest;
    wait_first = j.len + 3;
    wait_last  = wait_first + TIMEOUT - 1;
    if (j.early > 0) begin
      kind = K_ERR; rel = j.early; return;
    end
    a1 = (j.dex  == NONE) ? 100000 : j.len + 2 + j.dex;
    a2 = (j.dex2 == NONE) ? 100000 : j.len + 2 + j.dex2;
    latest = (a1 > a2) ? a1 : a2;
    if (latest <= wait_last) begin
      kind = K_DONE;
      rel  = (latest + 1 > wait_first + 1) ? latest + 1 : wait_first + 1;
    end else begin
      kind = K_ERR; rel = wait_last;
    end
  endfunction

  task automatic run_job(input job_t j, input int exp_kind, input int exp_rel);
    int ex_rel, ex2_rel, end_rel, done_rel, err_rel, n_done, n_err, cfg_bad, exp_rd;
    int rd_a[$], rd_r[$], v_x[$], v_r[$];
    end_rel = -1; done_rel = -1; err_rel = -1; n_done = 0; n_err = 0; cfg_bad = 0;
    ex_rel  = (j.early > 0 || j.dex  == NONE) ? -5 : j.len + 2 + j.dex;
    ex2_rel = (j.early > 0 || j.dex2 == NONE) ? -5 : j.len + 2 + j.dex2;
    chk({j.name, "_cfg_pre_alpha"}, int'(unit_alpha), cur_alpha);
    chk({j.name, "_cfg_pre_inv"},   int'(unit_inv_n), cur_inv);
    start = 1'b1; len = 8'(j.len); base = 8'(j.base); alpha = 2'(j.alpha); inv_n = 8'(j.inv_n);
    @(posedge clk);
    cur_alpha = j.alpha; cur_inv = j.inv_n;
    for (int rel = 1; rel <= 400; rel++) begin
      @(negedge clk);
      start = (rel == j.poke);
      if (rel == 1 || rel == j.poke) begin
        len = 8'($urandom); base = 8'($urandom); alpha = 2'($urandom); inv_n = 8'($urandom);
      end
      ex_done  = (rel == ex_rel) || (rel == j.early);
      ex2_done = (rel == ex2_rel);
      ex  = ex_done  ? 8'(j.ex)  : 8'($urandom);
      ex2 = ex2_done ? 8'(j.ex2) : 8'($urandom);
      #1;
      if (rd_en) begin rd_a.push_back(int'(rd_addr)); rd_r.push_back(rel); end
      if (unit_valid) begin v_x.push_back(int'(unit_x)); v_r.push_back(rel); end
      if (busy && (int'(unit_alpha) != j.alpha || int'(unit_inv_n) != j.inv_n)) cfg_bad++;
      if (done) begin
        n_done++; done_rel = rel;
        chk({j.name, "_mean_at_done"}, int'(mean_o), j.ex);
        chk({j.name, "_ex2_at_done"},  int'(ex2_o),  j.ex2);
      end
      if (err) begin n_err++; err_rel = rel; end
      if (!busy) begin end_rel = rel; break; end
    end
    start = 1'b0; ex_done = 1'b0; ex2_done = 1'b0;

    chk({j.name, "_busy_fall"}, end_rel, exp_rel + 1);
    chk({j.name, "_cfg_held"}, cfg_bad, 0);
    exp_rd = (j.early > 0) ? j.early : j.len;
    chk({j.name, "_rd_count"}, rd_a.size(), exp_rd);
    for (int i = 0; i < rd_a.size() && i < exp_rd; i++) begin
      chk($sformatf("%s_rd_addr%0d", j.name, i), rd_a[i], (j.base + i) % 256);
      chk($sformatf("%s_rd_cyc%0d", j.name, i),  rd_r[i], 1 + i);
    end
    if (j.early == 0) begin
      chk({j.name, "_valid_count"}, v_x.size(), j.len);
      for (int i = 0; i < v_x.size() && i < j.len; i++) begin
        chk($sformatf("%s_x%0d", j.name, i),      v_x[i], int'(mem[(j.base + i) % 256]));
        chk($sformatf("%s_x_cyc%0d", j.name, i), v_r[i], 3 + i);
      end
    end
    if (exp_kind == K_DONE) begin
      chk({j.name, "_done_count"}, n_done, 1);
      chk({j.name, "_err_count"},  n_err, 0);
      chk({j.name, "_done_cyc"},   done_rel, exp_rel);
      held_mean = j.ex; held_ex2 = j.ex2;
    end else begin
      chk({j.name, "_err_count"},  n_err, 1);
      chk({j.name, "_done_count"}, n_done, 0);
      chk({j.name, "_err_cyc"},    err_rel, exp_rel);
    end
    chk({j.name, "_mean_held"}, int'(mean_o), held_mean);
    chk({j.name, "_ex2_held"},  int'(ex2_o),  held_ex2);
    $display("job %-12s len=%0d base=0x%02h end=%0d done_cyc=%0d err_cyc=%0d reads=%0d elems=%0d",
             j.name, j.len, j.base, end_rel, done_rel, err_rel, rd_a.size(), v_x.size());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    job_t tbl[11];
    job_t j;
    int kind, rel, mode, cnt_rd, cnt_busy, pulses;

    rstn = 1'b0; start = 1'b0; len = '0; base = '0; alpha = '0; inv_n = '0;
    ex_done = 1'b0; ex2_done = 1'b0; ex = '0; ex2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
    for (int i = 0; i < 16; i++) mem[8'h20 + i] = 9'(i + 1);

    tbl[0]  = mk("nominal",    16, 'h20, 2, 32,   3,    3, 'h11, 'h5D, 0, 0, 0, K_DONE, 22);
    tbl[1]  = mk("addr_wrap",   4, 'hFE, 1, 64,   2,    2, 'h22, 'h33, 0, 0, 0, K_DONE, 9);
    tbl[2]  = mk("ex2_first",   8, 'h40, 3, 16,   7,    2, 'h44, 'h55, 0, 0, 0, K_DONE, 18);
    tbl[3]  = mk("same_cycle",  8, 'h48, 0,  8,   4,    4, 'h66, 'h77, 0, 0, 1, K_DONE, 15);
    tbl[4]  = mk("early_done", 10, 'h50, 1, 10, NONE, NONE, 'h01, 'h02, 4, 0, 0, K_ERR, 4);
    tbl[5]  = mk("timeout",     5, 'h60, 2, 50, NONE, NONE, 'h03, 'h04, 0, 0, 0, K_ERR, 71);
    tbl[6]  = mk("last_wait",   5, 'h68, 3, 51,  64,    1, 'h88, 'h99, 0, 0, 0, K_DONE, 72);
    tbl[7]  = mk("late_done",   5, 'h70, 1, 52,  65,    1, 'h0A, 'h0B, 0, 0, 0, K_ERR, 71);
    tbl[8]  = mk("busy_start",  6, 'h78, 2, 40,   2,    2, 'hAB, 'hCD, 0, 3, 0, K_DONE, 11);
    tbl[9]  = mk("len_one",     1, 'h80, 1, 255,  1,    1, 'h12, 'h34, 0, 0, 0, K_DONE, 5);
    tbl[10] = mk("drain_done",  3, 'h90, 0,  7,   0,   -1, 'h56, 'h78, 0, 0, 1, K_DONE, 7);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_zero("reset");
    rstn = 1'b1;
    idle_cycles(1);

    // Zero-length request: immediate fault, nothing read, nothing latched.
    start = 1'b1; len = '0; base = 8'h33; alpha = 2'd3; inv_n = 8'd99;
    #1;
    chk("zero_len_err", int'(err), 1);
    chk("zero_len_busy", int'(busy), 0);
    @(negedge clk); start = 1'b0;
    cnt_rd = 0; cnt_busy = 0;
    for (int i = 0; i < 4; i++) begin
      #1; cnt_rd += int'(rd_en); cnt_busy += int'(busy);
      @(negedge clk);
    end
    #1;
    chk("zero_len_reads", cnt_rd, 0);
    chk("zero_len_busy_cycles", cnt_busy, 0);
    chk("zero_len_cfg", int'(unit_alpha), 0);
    $display("job zero_len     err pulse checked");

    for (int t = 0; t < 11; t++) begin
      if (tbl[t].b2b == 0) begin
        idle_cycles(2);
        chk({tbl[t].name, "_idle_before"}, int'(busy), 0);
      end
      run_job(tbl[t], tbl[t].exp_kind, tbl[t].exp_rel);
    end

    for (int r = 0; r < 12; r++) begin
      j = mk($sformatf("rand%0d", r), int'($urandom_range(1, 40)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 31)) - 1, int'($urandom_range(0, 31)) - 1,
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             0, 0, int'($urandom_range(0, 1)), 0, 0);
      mode = int'($urandom_range(0, 7));
      if (mode == 0) j.early = int'($urandom_range(1, j.len));
      else if (mode == 1) j.dex2 = NONE;
      else if (mode == 2) j.dex = 60 + int'($urandom_range(0, 6));
      model(j, kind, rel);
      if (j.b2b == 0) idle_cycles(2);
      run_job(j, kind, rel);
    end

    // Reset in the middle of streaming, on the cycle of the 7th read.
    idle_cycles(2);
    start = 1'b1; len = 8'd16; base = 8'h10; alpha = 2'd3; inv_n = 8'd9;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("mid_rd_en_before_reset", int'(rd_en), 1);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk_zero("reset_mid");
    rstn = 1'b1;
    held_mean = 0; held_ex2 = 0; cur_alpha = 0; cur_inv = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      pulses += int'(err) + int'(done) + int'(busy);
    end
    chk("reset_no_pulse", pulses, 0);
    j = mk("after_reset", 12, 'hA0, 2, 77, 5, 6, 'h3C, 'h5A, 0, 0, 0, K_DONE, 21);
    run_job(j, j.exp_kind, j.exp_rel);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
